// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions.
// Holds the receive FSM state type, the bit-period constants (in clk cycles
// at 50 MHz) for the supported baud rates, and a helper that maps a requested
// baud rate to its bit period. The transmit side can reuse the same helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Width of the bit-period and cycle-counter values (10416 fits in 14 bits).
  localparam int unsigned CNT_W = 14;

  localparam logic [CNT_W-1:0] BIT_CYC_4800    = 14'd10416;
  localparam logic [CNT_W-1:0] BIT_CYC_9600    = 14'd5208;
  localparam logic [CNT_W-1:0] BIT_CYC_14400   = 14'd3472;
  localparam logic [CNT_W-1:0] BIT_CYC_19200   = 14'd2604;
  localparam logic [CNT_W-1:0] BIT_CYC_38400   = 14'd1302;
  localparam logic [CNT_W-1:0] BIT_CYC_57600   = 14'd868;
  localparam logic [CNT_W-1:0] BIT_CYC_DEFAULT = 14'd5208;

  // Map a requested baud rate to a bit period; unknown rates fall back to 9600.
  function automatic logic [CNT_W-1:0] baud_to_bit_cyc(input logic [16:0] baud);
    logic [CNT_W-1:0] cyc;
    case (baud)
      17'd4800:  cyc = BIT_CYC_4800;
      17'd9600:  cyc = BIT_CYC_9600;
      17'd14400: cyc = BIT_CYC_14400;
      17'd19200: cyc = BIT_CYC_19200;
      17'd38400: cyc = BIT_CYC_38400;
      17'd57600: cyc = BIT_CYC_57600;
      default:   cyc = BIT_CYC_DEFAULT;
    endcase
    return cyc;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- signal bundle between a UART receiver and its user.
//   baud      : requested baud rate in bits/s (user -> receiver)
//   rx        : serial line, idle high, asynchronous to clk (line -> receiver)
//   rx_data   : last correctly framed byte (receiver -> user)
//   rx_valid  : one-clk pulse, rx_data holds a new byte
//   frame_err : one-clk pulse, stop bit sampled low
//   busy      : receiver is inside a frame
// The slave modport is the receiver's view; master is the user/line side.
interface uart_rx_if;
  import uart_pkg::*;

  logic [16:0] baud;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        busy;

  modport slave (
    input  baud,
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport master (
    output baud,
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- two-flop synchronizer for a single idle-high signal.
//   clk : destination clock
//   rst : asynchronous active-low reset; both flops reset to 1 (line idle)
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles after d
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver.
//   clk : 50 MHz system clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : uart_rx_if.slave -- baud and rx in; rx_data, rx_valid, frame_err,
//         busy out (all outputs registered)
// A 1->0 edge on the synchronized line starts a frame. The start bit is
// re-checked at its middle, data bits are sampled every bit period from
// there (LSB first), and the stop bit is sampled one period after the last
// data bit. The stop-bit decision is registered once more before it drives
// rx_valid / frame_err, so each pulse appears one clk after the stop sample.
module uart_rx
  import uart_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  logic             rx_s;
  logic             rx_p;

  rx_state_e        state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [2:0]       bit_idx_r, bit_idx_nxt;
  logic [7:0]       shift_r, shift_nxt;
  logic [CNT_W-1:0] bit_cyc_r, bit_cyc_nxt;
  logic             done_ok_r, done_ok_nxt;
  logic             done_bad_r, done_bad_nxt;

  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             frame_err_r;
  logic             busy_r;

  logic [CNT_W-1:0] full_last_s;
  logic [CNT_W-1:0] half_last_s;
  logic             start_det_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // Previous-cycle copy of the synchronized line for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p <= 1'b1;
    end else begin
      rx_p <= rx_s;
    end
  end

  // The half period truncates for odd bit periods.
  assign full_last_s = bit_cyc_r - 14'd1;
  assign half_last_s = (bit_cyc_r >> 1) - 14'd1;
  // Only a genuine falling edge starts a frame, so a held-low line cannot retrigger.
  assign start_det_s = rx_p & ~rx_s;

  // Next-state, counter and shift-register logic of the receive FSM.
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r + 14'd1;
    bit_idx_nxt  = bit_idx_r;
    shift_nxt    = shift_r;
    bit_cyc_nxt  = bit_cyc_r;
    done_ok_nxt  = 1'b0;
    done_bad_nxt = 1'b0;

    case (state_r)
      IDLE: begin
        cnt_nxt = 14'd0;
        if (start_det_s) begin
          state_nxt   = START;
          bit_idx_nxt = 3'd0;
          // Bit period is frozen for the whole frame.
          bit_cyc_nxt = baud_to_bit_cyc(bus.baud);
        end else begin
          state_nxt = IDLE;
        end
      end

      START: begin
        if (cnt_r == half_last_s) begin
          cnt_nxt = 14'd0;
          if (!rx_s) begin
            state_nxt = DATA;
          end else begin
            // Glitch or short low pulse: drop it silently.
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = START;
        end
      end

      DATA: begin
        if (cnt_r == full_last_s) begin
          cnt_nxt              = 14'd0;
          shift_nxt[bit_idx_r] = rx_s;
          if (bit_idx_r == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx_r + 3'd1;
          end
        end else begin
          state_nxt = DATA;
        end
      end

      STOP: begin
        if (cnt_r == full_last_s) begin
          cnt_nxt = 14'd0;
          // Leaving mid stop bit leaves room for a back-to-back start edge.
          state_nxt = IDLE;
          if (rx_s) begin
            done_ok_nxt = 1'b1;
          end else begin
            done_bad_nxt = 1'b1;
          end
        end else begin
          state_nxt = STOP;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 14'd0;
      end
    endcase
  end

  // FSM state, counters, shift register and stop-bit decision flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 14'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      bit_cyc_r  <= BIT_CYC_DEFAULT;
      done_ok_r  <= 1'b0;
      done_bad_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      bit_idx_r  <= bit_idx_nxt;
      shift_r    <= shift_nxt;
      bit_cyc_r  <= bit_cyc_nxt;
      done_ok_r  <= done_ok_nxt;
      done_bad_r <= done_bad_nxt;
    end
  end

  // Registered outputs; ok and bad flags are mutually exclusive by construction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_valid_r  <= done_ok_r;
      frame_err_r <= done_bad_r;
      busy_r      <= (state_nxt != IDLE);
      if (done_ok_r) begin
        rx_data_r <= shift_r;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx.
// Table 1: false starts at every supported baud plus an unknown one; the
// length of the busy window equals BIT_CYC/2, which exposes the baud map.
// Table 2: framed bytes at 57600 timing (frame error with held-low line,
// mid-frame baud change). Hand sequences: back-to-back frames, reset mid-frame.
module tb_uart_rx;

  logic clk;
  logic rst;
  uart_rx_if bus ();

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: counts pulses and logs captured bytes with their cycle.
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         last_valid_cyc = 0;
  int         last_ferr_cyc  = 0;
  logic [7:0] cap_data [0:15];
  int         cap_cyc  [0:15];

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rx_valid && bus.frame_err) both_cnt = both_cnt + 1;
      if (bus.rx_valid) begin
        cap_data[valid_cnt % 16] = bus.rx_data;
        cap_cyc[valid_cnt % 16]  = cyc;
        last_valid_cyc = cyc;
        valid_cnt = valid_cnt + 1;
      end
      if (bus.frame_err) begin
        last_ferr_cyc = cyc;
        ferr_cnt = ferr_cnt + 1;
      end
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drives one 8N1 frame; must be called right after a negedge. Leaves the
  // line at the stop value after a full stop bit. chg_baud is applied after
  // the start bit to show the frame keeps its latched period.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int bc,
                            input logic [16:0] chg_baud, output int start_cyc);
    bus.rx = 1'b0;
    start_cyc = cyc;
    repeat (bc) @(negedge clk);
    bus.baud = chg_baud;
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (bc) @(negedge clk);
    end
    bus.rx = stop_v;
    repeat (bc) @(negedge clk);
  endtask

  typedef struct {
    logic [16:0] baud;
    int          low;
    int          exp_half;
  } fs_vec_t;

  typedef struct {
    logic [16:0] baud;
    logic [16:0] chg_baud;
    logic [7:0]  data;
    logic        stop_v;
    int          hold_low;
    int          exp_valid;
    int          exp_ferr;
    logic [7:0]  exp_data;
  } fr_vec_t;

  fs_vec_t fs [0:6];
  fr_vec_t fr [0:1];

  // 57600 timing: detect 3 + half 434 + 9*868 + 1 output stage.
  localparam int BC57  = 868;
  localparam int LAT57 = 3 + 434 + 9 * 868 + 1;

  initial begin
    int v0, f0, sc, sc2, first, len, busy_seen;
    logic fell;

    fs[0] = '{17'd4800,  1000, 5208};
    fs[1] = '{17'd9600,  1000, 2604};
    fs[2] = '{17'd14400, 200,  1736};
    fs[3] = '{17'd19200, 200,  1302};
    fs[4] = '{17'd38400, 200,  651};
    fs[5] = '{17'd57600, 200,  434};
    fs[6] = '{17'd12345, 200,  2604};

    fr[0] = '{17'd57600, 17'd57600, 8'h3C, 1'b0, 3000, 0, 1, 8'h00};
    fr[1] = '{17'd57600, 17'd4800,  8'h5A, 1'b1, 0,    1, 0, 8'h5A};

    bus.baud = 17'd9600;
    bus.rx   = 1'b1;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // False starts: busy must rise 3 clk after the edge and last BIT_CYC/2.
    for (int i = 0; i < 7; i++) begin
      bus.baud = fs[i].baud;
      repeat (20) @(negedge clk);
      v0 = valid_cnt;
      f0 = ferr_cnt;
      bus.rx = 1'b0;
      first = -1;
      len = 0;
      fell = 1'b0;
      for (int k = 1; k <= 12000 && !fell; k++) begin
        @(negedge clk);
        if (k == fs[i].low) bus.rx = 1'b1;
        if (bus.busy) begin
          if (first < 0) first = k;
          len = len + 1;
        end else if (first >= 0) begin
          fell = 1'b1;
        end
      end
      bus.rx = 1'b1;
      check($sformatf("fs%0d_busy_start", i), first, 3);
      check($sformatf("fs%0d_busy_len", i), len, fs[i].exp_half);
      check($sformatf("fs%0d_no_pulse", i), (valid_cnt - v0) + (ferr_cnt - f0), 0);
    end

    // Framed bytes, all timed at 868 clk per bit.
    for (int i = 0; i < 2; i++) begin
      bus.baud = fr[i].baud;
      repeat (20) @(negedge clk);
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(fr[i].data, fr[i].stop_v, BC57, fr[i].chg_baud, sc);
      if (fr[i].hold_low > 0) begin
        busy_seen = 0;
        repeat (fr[i].hold_low) begin
          @(negedge clk);
          if (bus.busy) busy_seen = busy_seen + 1;
        end
        check($sformatf("fr%0d_held_low_idle", i), busy_seen, 0);
      end
      bus.rx = 1'b1;
      repeat (100) @(negedge clk);
      check($sformatf("fr%0d_valid_pulses", i), valid_cnt - v0, fr[i].exp_valid);
      check($sformatf("fr%0d_ferr_pulses", i), ferr_cnt - f0, fr[i].exp_ferr);
      check($sformatf("fr%0d_rx_data", i), bus.rx_data, fr[i].exp_data);
      if (fr[i].exp_valid != 0)
        check($sformatf("fr%0d_latency", i), last_valid_cyc - sc, LAT57);
      else
        check($sformatf("fr%0d_latency", i), last_ferr_cyc - sc, LAT57);
      check($sformatf("fr%0d_busy_after", i), bus.busy, 1'b0);
    end

    // Back-to-back frames with a single stop bit.
    bus.baud = 17'd57600;
    repeat (20) @(negedge clk);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b1, BC57, 17'd57600, sc);
    send_frame(8'hFF, 1'b1, BC57, 17'd57600, sc2);
    repeat (100) @(negedge clk);
    check("b2b_valid_pulses", valid_cnt - v0, 2);
    check("b2b_ferr_pulses", ferr_cnt - f0, 0);
    check("b2b_first_byte", cap_data[v0 % 16], 8'h00);
    check("b2b_second_byte", cap_data[(v0 + 1) % 16], 8'hFF);
    check("b2b_first_latency", cap_cyc[v0 % 16] - sc, LAT57);
    check("b2b_second_latency", cap_cyc[(v0 + 1) % 16] - sc2, LAT57);

    // Reset asserted in the middle of data bit 4.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bus.rx = 1'b0;
    repeat (BC57) @(negedge clk);
    bus.rx = 1'b1;
    repeat (4 * BC57) @(negedge clk);
    bus.rx = 1'b0;
    repeat (400) @(negedge clk);
    check("abort_busy_before", bus.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_rx_data", bus.rx_data, 8'h00);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_rx_valid", bus.rx_valid, 1'b0);
    check("abort_frame_err", bus.frame_err, 1'b0);
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2000) @(negedge clk);
    check("abort_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    check("abort_idle", bus.busy, 1'b0);
    send_frame(8'h81, 1'b1, BC57, 17'd57600, sc);
    repeat (100) @(negedge clk);
    check("post_reset_valid", valid_cnt - v0, 1);
    check("post_reset_data", bus.rx_data, 8'h81);

    check("never_both_pulses", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
